u74hc595_sipo: RTL and testbench

//  Cycle-based model of a 74HC595 8-bit serial-in/parallel-out shift register with output latch.

---
 rtl/u74hc595_sipo.sv | 86 ++++++++
 tb/tb_u74hc595_sipo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/u74hc595_sipo.sv
// Cycle-based 74HC595 serial-in/parallel-out shift register with storage latch and output delay pipe.
// Optional tri-state q outputs are enabled by defining U74HC595_TRISTATE_EN.
module u74hc595_sipo #(
  parameter int         DELAY = 2,     // output delay in clk cycles, 1..15
  parameter logic [7:0] IC    = 8'h00  // power-on/reset value of sr and st
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser,
  input  logic       srclk,
  input  logic       rclk,
  input  logic       srclr_n,
  input  logic       oe_n,
  output logic [7:0] q,
  output logic       qh_prime,
  input  logic       vcc,
  input  logic       gnd
);

  typedef struct packed {
    logic [7:0] st;
    logic       qh;
  } tap_t;

  logic [7:0]            sr_q, sr_d;
  logic [7:0]            st_q, st_d;
  logic                  srclk_dly_q, srclk_dly_d;
  logic                  rclk_dly_q, rclk_dly_d;
  tap_t [DELAY-1:0]      pipe_q, pipe_d;
  logic                  sr_edge, r_edge;
  tap_t                  tap_out;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch can be inferred.
    sr_edge     = srclk & ~srclk_dly_q;
    r_edge      = rclk & ~rclk_dly_q;
    srclk_dly_d = srclk;
    rclk_dly_d  = rclk;

    sr_d = sr_q;
    if (!srclr_n)     sr_d = 8'h00;
    else if (sr_edge) sr_d = {sr_q[6:0], ser};

    // Storage takes the pre-shift byte, so a simultaneous shift+latch stores the old value.
    st_d = r_edge ? sr_q : st_q;

    // Stage 0 loads the next-state values, so a change on edge N reaches the last stage on edge N+DELAY-1.
    pipe_d    = pipe_q;
    pipe_d[0] = '{st: st_d, qh: sr_d[7]};
    for (int i = 1; i < DELAY; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q        <= IC;
      st_q        <= IC;
      srclk_dly_q <= 1'b0;
      rclk_dly_q  <= 1'b0;
      // NOTE: the delay pipe is reset too, so outputs show IC immediately during reset.
      pipe_q      <= {DELAY{IC, IC[7]}};
    end else begin
      // NOTE: non-blocking assignments keep all state updates on the same edge order-independent.
      sr_q        <= sr_d;
      st_q        <= st_d;
      srclk_dly_q <= srclk_dly_d;
      rclk_dly_q  <= rclk_dly_d;
      pipe_q      <= pipe_d;
    end
  end

  assign tap_out  = pipe_q[DELAY-1];
  assign qh_prime = tap_out.qh;

`ifdef U74HC595_TRISTATE_EN
  assign q = oe_n ? 8'bz : tap_out.st;

  logic unused_pins;
  assign unused_pins = ^{vcc, gnd};
`else
  assign q = tap_out.st;

  logic unused_pins;
  assign unused_pins = ^{vcc, gnd, oe_n};
`endif

endmodule

// File: tb/tb_u74hc595_sipo.sv
// Self-checking bench for u74hc595_sipo: directed scenarios plus random pin activity against a
// behavioural model that keeps the output history in a queue.
module tb_u74hc595_sipo;
  localparam int         DELAY = 3;
  localparam logic [7:0] IC    = 8'hA5;

  logic       clk = 1'b0;
  logic       rst, ser, srclk, rclk, srclr_n, oe_n;
  logic [7:0] q;
  logic       qh_prime;

  int n_pass  = 0;
  int n_total = 0;

  u74hc595_sipo #(.DELAY(DELAY), .IC(IC)) dut (
    .clk(clk), .rst(rst), .ser(ser), .srclk(srclk), .rclk(rclk),
    .srclr_n(srclr_n), .oe_n(oe_n), .q(q), .qh_prime(qh_prime),
    .vcc(1'b1), .gnd(1'b0)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference model: shift/storage registers as bytes, previous pin levels, and a
  // queue of post-edge {st, sr[7]} snapshots whose oldest entry is what the pins show.
  logic [7:0] m_sr, m_st;
  logic       m_srclk_prev, m_rclk_prev;
  logic [8:0] hist[$];

  function automatic void model_reset();
    m_sr = IC;
    m_st = IC;
    m_srclk_prev = 1'b0;
    m_rclk_prev  = 1'b0;
    hist.delete();
    repeat (DELAY) hist.push_back({IC, IC[7]});
  endfunction

  function automatic void model_edge();
    logic [7:0] old_sr;
    old_sr = m_sr;
    if (!srclr_n)                     m_sr = 8'h00;
    else if (srclk && !m_srclk_prev)  m_sr = {m_sr[6:0], ser};
    if (rclk && !m_rclk_prev)         m_st = old_sr;
    m_srclk_prev = srclk;
    m_rclk_prev  = rclk;
    hist.push_back({m_st, m_sr[7]});
    void'(hist.pop_front());
  endfunction

  function automatic logic [7:0] exp_q();
    logic [8:0] head;
`ifdef U74HC595_TRISTATE_EN
    if (oe_n) return 8'bz;
`endif
    head = hist[0];
    return head[8:1];
  endfunction

  function automatic logic exp_qh();
    logic [8:0] head;
    head = hist[0];
    return head[0];
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_q"},  q,                   exp_q());
    check({tag, "_qh"}, {7'b0, qh_prime},    {7'b0, exp_qh()});
  endtask

  // One clk edge: the model consumes the pin levels present at the edge; outputs checked 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check_outputs("tick");
  endtask

  // Asynchronous reset between edges; outputs must jump to IC without waiting for clk.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    check("rst_q",  q,                oe_n ? exp_q() : IC);
    check("rst_qh", {7'b0, qh_prime}, {7'b0, IC[7]});
    tick();
    rst = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    ser = b; srclk = 1'b1; tick();
    srclk = 1'b0; tick();
  endtask

  task automatic shift_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) shift_bit(v[i]);
  endtask

  // rclk edge, then DELAY-1 more edges: the latched byte is now on q.
  task automatic latch();
    rclk = 1'b1; tick();
    rclk = 1'b0;
    repeat (DELAY - 1) tick();
  endtask

  initial begin
    rst = 1'b1; ser = 1'b0; srclk = 1'b0; rclk = 1'b0; srclr_n = 1'b1; oe_n = 1'b0;
    model_reset();

    // Reset value visible immediately and held with no pin edges.
    #1;
    check("por_q",  q,                8'hA5);
    check("por_qh", {7'b0, qh_prime}, 8'h01);
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    check("idle_q",  q,                8'hA5);
    check("idle_qh", {7'b0, qh_prime}, 8'h01);

    // Serial byte B2, first bit ends up in QH.
    shift_byte(8'hB2);
    latch();
    check("b2_q", q, 8'hB2);

    // Simultaneous shift and latch stores the pre-shift byte.
    shift_byte(8'h0F);
    ser = 1'b1; srclk = 1'b1; rclk = 1'b1; tick();
    srclk = 1'b0; rclk = 1'b0;
    repeat (DELAY - 1) tick();
    check("same_edge_q",  q,                8'h0F);
    check("same_edge_qh", {7'b0, qh_prime}, 8'h00);
    latch();
    check("relatch_q", q, 8'h1F);

    // Clear wins over a coincident shift; storage untouched until the next latch.
    shift_byte(8'hFF);
    latch();
    check("ff_q", q, 8'hFF);
    srclr_n = 1'b0; srclk = 1'b1; tick();
    srclr_n = 1'b1; srclk = 1'b0;
    repeat (DELAY - 1) tick();
    check("clr_q",  q,                8'hFF);
    check("clr_qh", {7'b0, qh_prime}, 8'h00);
    latch();
    check("clr_latch_q", q, 8'h00);

    // Reset in the middle of a byte discards the partial shift.
    shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
    pulse_reset();
    check("midrst_q", q, 8'hA5);
    shift_byte(8'h3C);
    latch();
    check("after_rst_q", q, 8'h3C);

    // Output enable acts combinationally on q only.
    oe_n = 1'b1;
    #1;
`ifdef U74HC595_TRISTATE_EN
    check("oe_off_q", q, 8'bz);
`else
    check("oe_ignored_q", q, 8'h3C);
`endif
    check("oe_off_qh", {7'b0, qh_prime}, 8'h00);
    oe_n = 1'b0;
    #1;
    check("oe_on_q", q, 8'h3C);

    // Random pin activity with occasional asynchronous resets.
    for (int n = 0; n < 400; n++) begin
      ser     = 1'($urandom);
      srclk   = 1'($urandom);
      rclk    = ($urandom_range(3) == 0);
      srclr_n = ($urandom_range(7) != 0);
      oe_n    = ($urandom_range(3) == 0);
      tick();
      if ($urandom_range(59) == 0) pulse_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
